neuron_scheduler: RTL and testbench

Time-multiplexed sweep controller for the tinyODIN neuron core. It accepts presynaptic AER events and time-reference ticks and sequences one full sweep over all N neurons per event, driving the neuron core's read/write strobes, neuron counter, time-reference flag, and synapse-memory word fetches. It also arbitrates the shared neuron/synapse memories between sweeps and the OBI slave port. It sits between the AER/tick front-end and `neuron_core_charge`.

---
 rtl/neuron_scheduler.sv | 174 +++++++++++++++++
 tb/tb_neuron_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_scheduler.sv
// neuron_scheduler
// ----------------
// Sweep controller for the tinyODIN neuron core. Each accepted presynaptic
// AER event or pending time-reference tick starts one sweep over all N
// neurons: a one-cycle PREFETCH, N UPDATE cycles and a one-cycle DONE. The
// neuron core reads neuron (count+1) on neuron_event_read_o, so PREFETCH drives
// count_o = N-1 to make the core fetch neuron 0 by wrap-around. Synaptic
// sweeps also fetch one synapse word per four neurons, one cycle ahead of use.
// Between sweeps the shared memories may be handed to the OBI slave port.
//
// Optional feature: NEURON_SCHED_BUS_FAIR_EN
//   When defined, a bus request seen in DONE earns one guaranteed grant in the
//   next IDLE cycle, ahead of pending ticks and AER events. When undefined,
//   the bus is served only when no tick or event is waiting.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   aer_valid_i/ready_o      presynaptic event handshake
//   aer_addr_i               presynaptic neuron index (synapse row)
//   tick_i                   one-cycle time-reference pulse
//   bus_req_i / bus_gnt_o    OBI slave arbitration (grant is combinational)
//   neuron_event_read_o      neuron state read strobe
//   neuron_event_write_o     neuron state write-back strobe
//   neuron_tref_o            current sweep is a leak sweep
//   count_o                  neuron index
//   syn_rd_o / syn_addr_o    synapse word fetch, address {row, neuron[MSB:2]}
//   busy_o                   sweep in progress
//   sweep_done_o             one-cycle pulse at sweep end
//   tick_ovf_o               sticky: a tick was lost

module neuron_scheduler #(
    parameter int N = 256
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      aer_valid_i,
    output logic                      aer_ready_o,
    input  logic [$clog2(N)-1:0]      aer_addr_i,
    input  logic                      tick_i,
    input  logic                      bus_req_i,
    output logic                      bus_gnt_o,
    output logic                      neuron_event_read_o,
    output logic                      neuron_event_write_o,
    output logic                      neuron_tref_o,
    output logic [$clog2(N)-1:0]      count_o,
    output logic                      syn_rd_o,
    output logic [2*$clog2(N)-3:0]    syn_addr_o,
    output logic                      busy_o,
    output logic                      sweep_done_o,
    output logic                      tick_ovf_o
);

    localparam int CW = $clog2(N);
    localparam int WW = CW - 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREFETCH = 2'd1;
    localparam logic [1:0] S_UPDATE   = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] row;
    logic          tref_mode;
    logic          tick_pend;
    logic          tick_ovf;

    logic          idle;
    logic          fair_slot;
    logic          start_tick;
    logic          start_aer;
    logic          in_pre;
    logic          in_upd;
    logic [WW-1:0] word;

    // Every output is forced low while RST is asserted, not only after the
    // reset edge.
    assign idle = (state == S_IDLE) && !RST;

`ifdef NEURON_SCHED_BUS_FAIR_EN
    logic fair_pend;

    // One reserved IDLE cycle for the bus after a sweep that ended while the
    // bus was waiting; sweep starts are held off in that cycle.
    assign fair_slot = idle && fair_pend;

    always_ff @(posedge CLK) begin
        if (RST)
            fair_pend <= 1'b0;
        else if (state == S_DONE && bus_req_i)
            fair_pend <= 1'b1;
        else if (fair_slot)
            fair_pend <= 1'b0;
    end
`else
    assign fair_slot = 1'b0;
`endif

    // Start priority in IDLE: pending tick, then AER, then bus.
    assign start_tick  = idle && !fair_slot && tick_pend;
    assign bus_gnt_o   = fair_slot ? bus_req_i
                                   : (idle && bus_req_i && !tick_pend && !aer_valid_i);
    assign aer_ready_o = idle && !fair_slot && !tick_pend && !bus_gnt_o;
    assign start_aer   = aer_ready_o && aer_valid_i;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            row       <= '0;
            tref_mode <= 1'b0;
            tick_pend <= 1'b0;
            tick_ovf  <= 1'b0;
        end else begin
            // A tick in the same cycle as consumption re-arms the flag
            // without being counted as lost.
            tick_pend <= (tick_pend && !start_tick) || tick_i;
            if (tick_i && tick_pend && !start_tick)
                tick_ovf <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_tick) begin
                        state     <= S_PREFETCH;
                        tref_mode <= 1'b1;
                        cnt       <= LAST;
                    end else if (start_aer) begin
                        state     <= S_PREFETCH;
                        tref_mode <= 1'b0;
                        row       <= aer_addr_i;
                        cnt       <= LAST;
                    end
                end
                S_PREFETCH: begin
                    state <= S_UPDATE;
                    cnt   <= cnt + CW'(1);      // N-1 wraps to neuron 0
                end
                S_UPDATE: begin
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_pre = !RST && (state == S_PREFETCH);
    assign in_upd = !RST && (state == S_UPDATE);

    assign count_o              = (in_pre || in_upd) ? cnt : '0;
    assign neuron_event_read_o  = in_pre || (in_upd && cnt != LAST);
    assign neuron_event_write_o = in_upd;
    assign neuron_tref_o        = in_upd && tref_mode;

    // The word for neurons 4k..4k+3 is fetched while neuron 4k-1 is being
    // updated, so it is on the memory output exactly when neuron 4k arrives.
    // PREFETCH fetches word 0 for the same reason.
    assign syn_rd_o   = !tref_mode &&
                        (in_pre || (in_upd && cnt[1:0] == 2'b11 && cnt != LAST));
    assign word       = in_pre ? '0 : cnt[CW-1:2] + WW'(1);
    assign syn_addr_o = syn_rd_o ? {row, word} : '0;

    assign busy_o       = !RST && (state != S_IDLE);
    assign sweep_done_o = !RST && (state == S_DONE);
    assign tick_ovf_o   = !RST && tick_ovf;

endmodule

// File: tb/tb_neuron_scheduler.sv
module tb_neuron_scheduler;

    localparam int N  = 256;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * CW - 2;

    typedef struct packed {
        logic          ready;
        logic          gnt;
        logic          rd;
        logic          wr;
        logic          tref;
        logic [CW-1:0] cnt;
        logic          srd;
        logic [AW-1:0] saddr;
        logic          busy;
        logic          done;
        logic          ovf;
    } obs_t;

    typedef struct {
        string         name;
        logic          valid;
        logic          breq;
        logic [CW-1:0] addr;
        logic          ready;
        logic          gnt;
    } vec_t;

    logic          CLK;
    logic          RST;
    logic          aer_valid_i;
    logic          aer_ready_o;
    logic [CW-1:0] aer_addr_i;
    logic          tick_i;
    logic          bus_req_i;
    logic          bus_gnt_o;
    logic          neuron_event_read_o;
    logic          neuron_event_write_o;
    logic          neuron_tref_o;
    logic [CW-1:0] count_o;
    logic          syn_rd_o;
    logic [AW-1:0] syn_addr_o;
    logic          busy_o;
    logic          sweep_done_o;
    logic          tick_ovf_o;

    int n_vec = 0;
    int n_bad = 0;

    neuron_scheduler #(.N(N)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .aer_valid_i          (aer_valid_i),
        .aer_ready_o          (aer_ready_o),
        .aer_addr_i           (aer_addr_i),
        .tick_i               (tick_i),
        .bus_req_i            (bus_req_i),
        .bus_gnt_o            (bus_gnt_o),
        .neuron_event_read_o  (neuron_event_read_o),
        .neuron_event_write_o (neuron_event_write_o),
        .neuron_tref_o        (neuron_tref_o),
        .count_o              (count_o),
        .syn_rd_o             (syn_rd_o),
        .syn_addr_o           (syn_addr_o),
        .busy_o               (busy_o),
        .sweep_done_o         (sweep_done_o),
        .tick_ovf_o           (tick_ovf_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, required finish within 400000");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    function automatic obs_t idle_obs(input logic ready, input logic gnt, input logic ovf);
        obs_t o;
        o       = '0;
        o.ready = ready;
        o.gnt   = gnt;
        o.ovf   = ovf;
        return o;
    endfunction

    // Expected outputs for sweep cycle c (cycle 0 = start, 1 = PREFETCH,
    // 2..N+1 = UPDATE with neuron c-2, N+2 = DONE).
    function automatic obs_t sweep_obs(input int c, input logic [CW-1:0] row,
                                       input logic tref, input logic ovf);
        obs_t o;
        int   k;
        o      = '0;
        o.ovf  = ovf;
        o.busy = 1'b1;
        if (c == 1) begin
            o.rd  = 1'b1;
            o.cnt = CW'(N - 1);
            if (!tref) begin
                o.srd   = 1'b1;
                o.saddr = {row, (CW-2)'(0)};
            end
        end else if (c <= N + 1) begin
            k      = c - 2;
            o.wr   = 1'b1;
            o.rd   = (k < N - 1);
            o.tref = tref;
            o.cnt  = CW'(k);
            if (!tref && (k % 4 == 3) && k < N - 1) begin
                o.srd   = 1'b1;
                o.saddr = {row, (CW-2)'((k + 1) / 4)};
            end
        end else begin
            o.done = 1'b1;
        end
        return o;
    endfunction

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input obs_t exp);
        obs_t got;
        #2;
        got = {aer_ready_o, bus_gnt_o, neuron_event_read_o, neuron_event_write_o,
               neuron_tref_o, count_o, syn_rd_o, syn_addr_o, busy_o, sweep_done_o,
               tick_ovf_o};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic start_aer(input logic [CW-1:0] row, input logic ovf);
        aer_valid_i = 1'b1;
        aer_addr_i  = row;
        chk($sformatf("aer_accept_r%0d", row), idle_obs(1'b1, 1'b0, ovf));
        next();
        aer_valid_i = 1'b0;
    endtask

    // Checks cycles 1..N+2 of a sweep; optional tick pulses at cycles ta/tb.
    // Stops right after checking cycle stop_at when that is non-zero.
    task automatic run_sweep(input logic [CW-1:0] row, input logic tref, input logic ovf0,
                             input int ta, input int tb, input int stop_at);
        logic ovf;
        for (int c = 1; c <= N + 2; c++) begin
            tick_i = (c == ta) || (c == tb);
            ovf    = ovf0 || (ta != 0 && tb != 0 && c > tb);
            chk($sformatf("sweep_r%0d_t%0d_c%0d", row, tref, c), sweep_obs(c, row, tref, ovf));
            if (c == stop_at) begin
                tick_i = 1'b0;
                return;
            end
            next();
        end
        tick_i = 1'b0;
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"idle_quiet",     1'b0, 1'b0, CW'(0), 1'b1, 1'b0};
        vecs[1] = '{"idle_aer_only",  1'b1, 1'b0, CW'(2), 1'b1, 1'b0};
        vecs[2] = '{"idle_bus_only",  1'b0, 1'b1, CW'(0), 1'b0, 1'b1};
        vecs[3] = '{"idle_aer_beats_bus", 1'b1, 1'b1, CW'(4), 1'b1, 1'b0};

        // Reset with every request active: all outputs low.
        RST         = 1'b1;
        aer_valid_i = 1'b1;
        aer_addr_i  = '0;
        tick_i      = 1'b0;
        bus_req_i   = 1'b1;
        next();
        next();
        chk("reset_outputs", '0);
        aer_valid_i = 1'b0;
        bus_req_i   = 1'b0;
        RST         = 1'b0;
        next();

        // IDLE arbitration table; requests are withdrawn before the edge.
        for (int i = 0; i < 4; i++) begin
            aer_valid_i = vecs[i].valid;
            bus_req_i   = vecs[i].breq;
            aer_addr_i  = vecs[i].addr;
            chk(vecs[i].name, idle_obs(vecs[i].ready, vecs[i].gnt, 1'b0));
            aer_valid_i = 1'b0;
            bus_req_i   = 1'b0;
            next();
        end

        // AER row 5 with the bus requesting throughout the sweep.
        bus_req_i = 1'b1;
        start_aer(CW'(5), 1'b0);
        run_sweep(CW'(5), 1'b0, 1'b0, 0, 0, 0);
        chk("bus_grant_after_sweep", idle_obs(1'b0, 1'b1, 1'b0));
        bus_req_i = 1'b0;
        next();

        // Tick in IDLE -> leak sweep one cycle later.
        tick_i = 1'b1;
        chk("tick_in_idle", idle_obs(1'b1, 1'b0, 1'b0));
        next();
        tick_i = 1'b0;
        chk("leak_start", idle_obs(1'b0, 1'b0, 1'b0));
        next();
        run_sweep(CW'(0), 1'b1, 1'b0, 0, 0, 0);
        chk("idle_after_leak", idle_obs(1'b1, 1'b0, 1'b0));
        next();

        // Two ticks during a synaptic sweep: one leak sweep, sticky overflow.
        start_aer(CW'(3), 1'b0);
        run_sweep(CW'(3), 1'b0, 1'b0, 10, 20, 0);
        chk("leak_after_ticks", idle_obs(1'b0, 1'b0, 1'b1));
        next();
        run_sweep(CW'(0), 1'b1, 1'b1, 0, 0, 0);
        chk("ovf_sticky", idle_obs(1'b1, 1'b0, 1'b1));
        next();
        next();
        chk("ovf_still_sticky", idle_obs(1'b1, 1'b0, 1'b1));
        RST = 1'b1;
        chk("ovf_under_rst", '0);
        next();
        RST = 1'b0;
        chk("ovf_cleared", idle_obs(1'b1, 1'b0, 1'b0));
        next();

        // Simultaneous tick and AER: AER first, leak sweep at cycle N+3.
        tick_i      = 1'b1;
        aer_valid_i = 1'b1;
        aer_addr_i  = CW'(7);
        chk("tick_and_aer_same", idle_obs(1'b1, 1'b0, 1'b0));
        next();
        tick_i      = 1'b0;
        aer_valid_i = 1'b0;
        run_sweep(CW'(7), 1'b0, 1'b0, 0, 0, 0);
        chk("leak_at_n_plus_3", idle_obs(1'b0, 1'b0, 1'b0));
        next();
        run_sweep(CW'(0), 1'b1, 1'b0, 0, 0, 0);
        chk("idle_after_queued_leak", idle_obs(1'b1, 1'b0, 1'b0));
        next();

        // Bus held with an AER event queued behind a running sweep.
        bus_req_i = 1'b1;
        start_aer(CW'(11), 1'b0);
        aer_valid_i = 1'b1;
        aer_addr_i  = CW'(12);
        run_sweep(CW'(11), 1'b0, 1'b0, 0, 0, 0);
`ifdef NEURON_SCHED_BUS_FAIR_EN
        chk("fair_bus_first", idle_obs(1'b0, 1'b1, 1'b0));
        next();
        chk("fair_then_aer", idle_obs(1'b1, 1'b0, 1'b0));
        next();
`else
        chk("strict_aer_first", idle_obs(1'b1, 1'b0, 1'b0));
        next();
`endif
        aer_valid_i = 1'b0;
        run_sweep(CW'(12), 1'b0, 1'b0, 0, 0, 0);
        chk("grant_when_no_event", idle_obs(1'b0, 1'b1, 1'b0));
        bus_req_i = 1'b0;
        next();

        // Reset at UPDATE count 100 (cycle 102), with a tick pending.
        start_aer(CW'(9), 1'b0);
        run_sweep(CW'(9), 1'b0, 1'b0, 50, 0, 102);
        RST = 1'b1;
        chk("rst_mid_sweep", '0);
        next();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("idle_after_rst_%0d", i), idle_obs(1'b1, 1'b0, 1'b0));
            next();
        end
        start_aer(CW'(13), 1'b0);
        run_sweep(CW'(13), 1'b0, 1'b0, 0, 0, 0);
        chk("idle_final", idle_obs(1'b1, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
